// File: rtl/quad_pkg.sv
// Shared phase constants, FSM encoding and phase-successor helper for the
// quadrature up/down decoder.
package quad_pkg;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  localparam logic ST_INIT  = 1'b0;
  localparam logic ST_TRACK = 1'b1;

  // Forward (count-up) order is 00 -> 01 -> 11 -> 10 -> 00; reverse is the inverse map.
  function automatic logic [1:0] next_fwd(input logic [1:0] phase);
    logic [1:0] nxt;
    case (phase)
      PH_00:   nxt = PH_01;
      PH_01:   nxt = PH_11;
      PH_11:   nxt = PH_10;
      default: nxt = PH_00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage flip-flop synchroniser for a single asynchronous bit, cleared by a
// synchronous active-high reset.
module sync_ff #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic q
);

  logic [N-1:0] stage_reg;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (srst) stage_reg[gi] <= 1'b0;
          else      stage_reg[gi] <= d;
        end
      end else begin : g_rest
        always_ff @(posedge clk) begin
          if (srst) stage_reg[gi] <= 1'b0;
          else      stage_reg[gi] <= stage_reg[gi-1];
        end
      end
    end
  endgenerate

  assign q = stage_reg[N-1];

endmodule

// File: rtl/quad_updown_decoder.sv
// Quadrature decoder: synchronises A/B, tracks the phase and drives a wrapping
// up/down position count with registered direction, step and error strobes.
module quad_updown_decoder
  import quad_pkg::*;
#(
  parameter int WIDTH       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CP,
  input  logic             CR,
  input  logic             A,
  input  logic             B,
  input  logic             EN,
  output logic [WIDTH-1:0] Q,
  output logic             Up_Down,
  output logic             Step,
  output logic             Err
);

  logic             a_s;
  logic             b_s;
  logic [1:0]       phase;
  logic [1:0]       pprev_reg;
  logic             state_reg;
  logic [2:0]       init_cnt_reg;
  logic [WIDTH-1:0] q_reg;
  logic             up_reg;
  logic             step_reg;
  logic             err_reg;
  logic             is_fwd;
  logic             is_rev;
  logic             is_jump;

  sync_ff #(.N(SYNC_STAGES)) u_sync_a (.clk(CP), .srst(CR), .d(A), .q(a_s));
  sync_ff #(.N(SYNC_STAGES)) u_sync_b (.clk(CP), .srst(CR), .d(B), .q(b_s));

  assign phase = {a_s, b_s};

  always_comb begin
    is_fwd  = (phase == next_fwd(pprev_reg));
    is_rev  = (pprev_reg == next_fwd(phase));
    is_jump = ((phase ^ pprev_reg) == 2'b11);
  end

  // INIT stays until the cleared synchroniser has refilled with the live pin
  // levels, so a level already present at reset release is never seen as motion.
  always_ff @(posedge CP) begin
    if (CR) begin
      state_reg    <= ST_INIT;
      init_cnt_reg <= '0;
      pprev_reg    <= PH_00;
      q_reg        <= '0;
      up_reg       <= 1'b1;
      step_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      step_reg  <= 1'b0;
      err_reg   <= 1'b0;
      pprev_reg <= phase;
      case (state_reg)
        ST_INIT: begin
          if (init_cnt_reg == 3'(SYNC_STAGES)) state_reg <= ST_TRACK;
          else                                 init_cnt_reg <= init_cnt_reg + 3'd1;
        end
        default: begin
          if (is_fwd) begin
            if (EN) begin
              q_reg    <= q_reg + WIDTH'(1);
              up_reg   <= 1'b1;
              step_reg <= 1'b1;
            end
          end else if (is_rev) begin
            if (EN) begin
              q_reg    <= q_reg - WIDTH'(1);
              up_reg   <= 1'b0;
              step_reg <= 1'b1;
            end
          end else if (is_jump) begin
            err_reg <= 1'b1;
          end
        end
      endcase
    end
  end

  assign Q       = q_reg;
  assign Up_Down = up_reg;
  assign Step    = step_reg;
  assign Err     = err_reg;

endmodule

// File: tb/tb_quad_updown_decoder.sv
// Directed bench for quad_updown_decoder: each phase change pushes its expected
// outcome to a scoreboard that a negedge monitor pops on the due cycle.
module tb_quad_updown_decoder;

  logic       clk = 1'b0;
  logic       CR;
  logic       A;
  logic       B;
  logic       EN;
  logic [2:0] Q;
  logic       Up_Down;
  logic       Step;
  logic       Err;

  quad_updown_decoder #(.WIDTH(3), .SYNC_STAGES(2)) dut (
    .CP(clk), .CR(CR), .A(A), .B(B), .EN(EN),
    .Q(Q), .Up_Down(Up_Down), .Step(Step), .Err(Err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [2:0] q;
    logic       ud;
    logic       step;
    logic       err;
    string      tag;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         total = 0;
  int         failed = 0;
  bit         mon_en = 0;
  logic [2:0] cur_q = 3'd0;
  logic       cur_ud = 1'b1;
  logic [2:0] m_q = 3'd0;
  logic       m_ud = 1'b1;
  logic [1:0] cur_ph;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] succ(input logic [1:0] p);
    logic [1:0] tbl [4];
    tbl[0] = 2'b01; tbl[1] = 2'b11; tbl[3] = 2'b10; tbl[2] = 2'b00;
    return tbl[p];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() != 0 && sb[0].due < cyc) begin
        exp_t late;
        late = sb.pop_front();
        chk({late.tag, "_missed"}, 8'(cyc), 8'(late.due));
      end
      if (sb.size() != 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, "_q"},    8'(Q),       8'(e.q));
        chk({e.tag, "_ud"},   8'(Up_Down), 8'(e.ud));
        chk({e.tag, "_step"}, 8'(Step),    8'(e.step));
        chk({e.tag, "_err"},  8'(Err),     8'(e.err));
        cur_q  = e.q;
        cur_ud = e.ud;
        $display("txn %-12s cycle=%0d Q=%0d Up_Down=%0b Step=%0b Err=%0b", e.tag, cyc, Q, Up_Down, Step, Err);
      end else begin
        chk("idle_q",    8'(Q),       8'(cur_q));
        chk("idle_ud",   8'(Up_Down), 8'(cur_ud));
        chk("idle_step", 8'(Step),    8'd0);
        chk("idle_err",  8'(Err),     8'd0);
      end
    end
  end

  // Drive a new phase just after a posedge; outcome is due three edges later.
  task automatic move(input logic [1:0] ph, input string tag);
    exp_t e;
    e.due = cyc + 3; e.step = 1'b0; e.err = 1'b0; e.tag = tag;
    if (ph == succ(cur_ph)) begin
      if (EN) begin m_q = m_q + 3'd1; m_ud = 1'b1; e.step = 1'b1; end
    end else if (cur_ph == succ(ph)) begin
      if (EN) begin m_q = m_q - 3'd1; m_ud = 1'b0; e.step = 1'b1; end
    end else if ((ph ^ cur_ph) == 2'b11) begin
      e.err = 1'b1;
    end
    e.q = m_q; e.ud = m_ud;
    sb.push_back(e);
    A = ph[1]; B = ph[0]; cur_ph = ph;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t rst_e;
    CR = 1'b1; A = 1'b1; B = 1'b1; EN = 1'b1; cur_ph = 2'b11;
    gap(3);
    mon_en = 1;
    gap(2);
    CR = 1'b0;
    gap(20);

    move(2'b00, "jump_11_00"); gap(5);
    move(2'b01, "fwd1"); gap(5);
    move(2'b11, "fwd2"); gap(5);
    move(2'b10, "fwd3"); gap(5);
    move(2'b00, "fwd4"); gap(5);

    move(2'b10, "rev3"); gap(5);
    move(2'b11, "rev2"); gap(5);
    move(2'b01, "rev1"); gap(5);
    move(2'b00, "rev0"); gap(5);
    move(2'b10, "rev_wrap7"); gap(5);
    for (int i = 0; i < 9; i++) begin
      move(succ(cur_ph), $sformatf("fwd_run%0d", i));
      gap(5);
    end

    move(2'b11, "jump_00_11"); gap(5);
    move(2'b10, "fwd_after_err"); gap(5);

    EN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      move(succ(cur_ph), $sformatf("en_off%0d", i));
      gap(5);
    end
    EN = 1'b1;
    move(succ(cur_ph), "en_back"); gap(5);

    // Reset lands on the very edge where this step would have been registered.
    move(succ(cur_ph), "rst_step");
    rst_e = sb.pop_back();
    rst_e.q = 3'd0; rst_e.ud = 1'b1; rst_e.step = 1'b0; rst_e.err = 1'b0;
    rst_e.tag = "rst_on_step";
    sb.push_back(rst_e);
    m_q = 3'd0; m_ud = 1'b1;
    gap(2);
    CR = 1'b1;
    gap(1);
    CR = 1'b0;
    gap(10);
    move(succ(cur_ph), "fwd_post_rst"); gap(5);

    for (int i = 0; i < 20 && sb.size() != 0; i++) gap(1);
    chk("sb_drain", 8'(sb.size()), 8'd0);
    gap(2);
    $display("%0d/%0d checks passed", total - failed, total);
    $finish;
  end

endmodule
